// File: rtl/nx_fifo_pkg.sv
// Shared types and helpers for the nx_fifo_wm watermark FIFO.
// NX_FIFO_PARITY_EN (when defined) widens storage by NX_FIFO_PAR_W bits.
package nx_fifo_pkg;

    localparam int NX_FIFO_PAR_W = 1;

    typedef struct packed {
        logic underflow;
        logic overflow;
    } nx_fifo_err_t;

    function automatic int nx_fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nx_fifo_wm_ctrl.sv
// Control path of nx_fifo_wm: explicit-wrap pointers, occupancy counter, flags,
// watermarks, high-water monitor and registered error pulses.
module nx_fifo_wm_ctrl
    import nx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = nx_fifo_cw(DEPTH),
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          wen,
    input  logic          ren,
    input  logic [CW-1:0] af_thresh,
    input  logic [CW-1:0] ae_thresh,
    output logic          wr_acc,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] used_slots,
    output logic [CW-1:0] free_slots,
    output logic [CW-1:0] high_water,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output nx_fifo_err_t  err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] used_q, used_d, hw_q, hw_d;
    nx_fifo_err_t  err_q, err_d;
    logic          rd_acc;

    // Non-power-of-two depth: wrap explicitly rather than relying on overflow.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign empty = (used_q == '0);
    assign full  = (used_q == DEPTH_C);

    always_comb begin
        wr_acc   = wen && (!full || ren) && !clear;
        rd_acc   = ren && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        err_d    = '0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
        end else begin
            if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
            if (wr_acc && !rd_acc)      used_d = used_q + CW'(1);
            else if (rd_acc && !wr_acc) used_d = used_q - CW'(1);
            err_d.underflow = ren && empty;
            err_d.overflow  = wen && full && !ren;
        end
        hw_d = clear ? '0 : ((used_d > hw_q) ? used_d : hw_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            hw_q     <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            hw_q     <= hw_d;
            err_q    <= err_d;
        end
    end

    assign wr_ptr       = wr_ptr_q;
    assign rd_ptr       = rd_ptr_q;
    assign used_slots   = used_q;
    assign free_slots   = DEPTH_C - used_q;
    assign high_water   = hw_q;
    assign almost_full  = (used_q >= af_thresh);
    assign almost_empty = (used_q <= ae_thresh);
    assign err          = err_q;

endmodule

// File: rtl/nx_fifo_wm.sv
// Synchronous show-ahead FIFO with arbitrary depth, watermarks and error pulses.
// Define NX_FIFO_PARITY_EN to store an even-parity bit per entry and expose parity_err.
module nx_fifo_wm
    import nx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 64,
    parameter int DATA_RESET = 1,
    localparam int CW        = nx_fifo_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [CW-1:0]    af_thresh,
    input  logic [CW-1:0]    ae_thresh,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic [CW-1:0]    high_water,
    output logic             underflow,
    output logic             overflow
`ifdef NX_FIFO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef NX_FIFO_PARITY_EN
    localparam int SW = WIDTH + NX_FIFO_PAR_W;
`else
    localparam int SW = WIDTH;
`endif

    logic [SW-1:0] mem_q [DEPTH];
    logic [SW-1:0] wentry, head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_acc;
    nx_fifo_err_t  err;

    nx_fifo_wm_ctrl #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .PW    (PW)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wen          (wen),
        .ren          (ren),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .wr_acc       (wr_acc),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .used_slots   (used_slots),
        .free_slots   (free_slots),
        .high_water   (high_water),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err          (err)
    );

`ifdef NX_FIFO_PARITY_EN
    assign wentry     = {^wdata, wdata};
    assign parity_err = !empty && (^head);
`else
    assign wentry = wdata;
`endif

    // Storage is deliberately left unreset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr] <= wentry;
    end

    assign head      = mem_q[rd_ptr];
    assign rdata     = ((DATA_RESET != 0) && empty) ? '0 : head[WIDTH-1:0];
    assign underflow = err.underflow;
    assign overflow  = err.overflow;

endmodule

// File: tb/tb_nx_fifo_wm.sv
// Bench for nx_fifo_wm (DEPTH=5, WIDTH=8): directed table, corner sequences, random vs queue model.
module tb_nx_fifo_wm;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst, clear, wen, ren;
    logic [WIDTH-1:0] wdata;
    logic [CW-1:0]    af_thresh, ae_thresh;
    logic [WIDTH-1:0] rdata;
    logic             empty, full, almost_full, almost_empty, underflow, overflow;
    logic [CW-1:0]    used_slots, free_slots, high_water;
`ifdef NX_FIFO_PARITY_EN
    logic             parity_err;
`endif

    nx_fifo_wm #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .rdata(rdata),
        .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
        .used_slots(used_slots), .free_slots(free_slots), .high_water(high_water),
        .underflow(underflow), .overflow(overflow)
`ifdef NX_FIFO_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a plain queue of accepted bytes plus tracked maxima and pulses.
    byte unsigned q[$];
    int           m_hw = 0;
    bit           m_uf = 0, m_of = 0;

    typedef struct {
        bit   w;
        bit   r;
        logic [7:0] d;
        int   used;
        int   rd;
        bit   uf;
        bit   of;
        bit   full;
        bit   empty;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        int  sz;
        bit  rd_ok, wr_ok;
        if (rst || clear) begin
            q.delete();
            m_hw = 0;
            m_uf = 0;
            m_of = 0;
        end else begin
            sz    = q.size();
            rd_ok = ren && (sz != 0);
            wr_ok = wen && ((sz != DEPTH) || ren);
            m_uf  = ren && (sz == 0);
            m_of  = wen && (sz == DEPTH) && !ren;
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(wdata);
            if (q.size() > m_hw) m_hw = q.size();
        end
    endtask

    task automatic step(input bit w, input bit r, input logic [7:0] d,
                        input bit c = 0, input bit rs = 0);
        wen = w; ren = r; wdata = d; clear = c; rst = rs;
        @(posedge clk);
        model_step();
        #1;
        wen = 0; ren = 0; clear = 0; rst = 0;
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("used", int'(used_slots), sz);
        chk("free", int'(free_slots), DEPTH - sz);
        chk("empty", int'(empty), int'(sz == 0));
        chk("full", int'(full), int'(sz == DEPTH));
        chk("almost_full", int'(almost_full), int'(sz >= int'(af_thresh)));
        chk("almost_empty", int'(almost_empty), int'(sz <= int'(ae_thresh)));
        chk("high_water", int'(high_water), m_hw);
        chk("underflow", int'(underflow), int'(m_uf));
        chk("overflow", int'(overflow), int'(m_of));
        chk("rdata", int'(rdata), (sz == 0) ? 0 : int'(q[0]));
`ifdef NX_FIFO_PARITY_EN
        chk("parity_err", int'(parity_err), 0);
`endif
    endtask

    initial begin
        rst = 1; clear = 0; wen = 0; ren = 0; wdata = '0;
        af_thresh = 3'd4; ae_thresh = 3'd1;

        tbl[0]  = '{1, 0, 8'h01, 1, 8'h01, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 8'h02, 2, 8'h01, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 8'h03, 3, 8'h01, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 8'h04, 4, 8'h01, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 8'h05, 5, 8'h01, 0, 0, 1, 0};
        tbl[5]  = '{1, 0, 8'h06, 5, 8'h01, 0, 1, 1, 0};
        tbl[6]  = '{0, 1, 8'h00, 4, 8'h02, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 8'h00, 3, 8'h03, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 8'h07, 4, 8'h03, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 8'h00, 3, 8'h04, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 8'h00, 2, 8'h05, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 8'h00, 1, 8'h07, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 1};
        tbl[13] = '{0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 1};
        tbl[14] = '{1, 1, 8'hAA, 1, 8'hAA, 1, 0, 0, 0};
        tbl[15] = '{0, 0, 8'h00, 1, 8'hAA, 0, 0, 0, 0};

        // Reset state
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        check_model();
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_free", int'(free_slots), DEPTH);
        af_thresh = 3'd0;
        #1;
        chk("rst_af_thresh0", int'(almost_full), 1);
        af_thresh = 3'd4;
        #1;

        // Directed table: fill, overflow, drain across wrap, underflow, no bypass
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_used", i), int'(used_slots), tbl[i].used);
            chk($sformatf("tbl%0d_rdata", i), int'(rdata), tbl[i].rd);
            chk($sformatf("tbl%0d_uf", i), int'(underflow), int'(tbl[i].uf));
            chk($sformatf("tbl%0d_of", i), int'(overflow), int'(tbl[i].of));
            chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].empty));
            check_model();
        end

        // Full with simultaneous read/write: count holds, order preserved
        for (int i = 0; i < 4; i++) step(1, 0, 8'hB0 + 8'(i));
        chk("full_before_rw", int'(full), 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 8'hC0 + 8'(i));
            chk("full_rw_used", int'(used_slots), 5);
            chk("full_rw_of", int'(overflow), 0);
            check_model();
        end
        for (int i = 0; i < 5; i++) begin
            chk("drain_rdata", int'(rdata), 8'hC5 + i);
            step(0, 1, 8'h00);
            check_model();
        end

        // Watermarks, high-water and clear
        step(0, 0, 8'h00, 1);
        chk("clr_used", int'(used_slots), 0);
        chk("clr_hw", int'(high_water), 0);
        chk("clr_ae", int'(almost_empty), 1);
        chk("clr_af", int'(almost_full), 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 8'(k));
            chk($sformatf("wm%0d_ae", k), int'(almost_empty), int'(k <= 1));
            chk($sformatf("wm%0d_af", k), int'(almost_full), int'(k >= 4));
            check_model();
        end
        chk("wm_hw", int'(high_water), 5);
        step(1, 1, 8'hEE, 1);
        chk("clr2_used", int'(used_slots), 0);
        chk("clr2_hw", int'(high_water), 0);
        chk("clr2_uf", int'(underflow), 0);
        chk("clr2_of", int'(overflow), 0);
        step(0, 0, 8'h00);
        chk("clr2_post_uf", int'(underflow), 0);
        chk("clr2_post_of", int'(overflow), 0);

        // Reset mid-traffic with a write pending
        for (int i = 0; i < 3; i++) step(1, 0, 8'h50 + 8'(i));
        step(1, 0, 8'h55, 0, 1);
        chk("rst_mid_empty", int'(empty), 1);
        chk("rst_mid_used", int'(used_slots), 0);
        chk("rst_mid_rdata", int'(rdata), 0);
        chk("rst_mid_uf", int'(underflow), 0);
        chk("rst_mid_of", int'(overflow), 0);
        check_model();

`ifdef NX_FIFO_PARITY_EN
        // Corrupt the stored head entry and confirm parity_err tracks it
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        chk("par_clean", int'(parity_err), 0);
        dut.mem_q[0] = dut.mem_q[0] ^ 9'h001;
        #1;
        chk("par_flip", int'(parity_err), 1);
        step(0, 1, 8'h00);
        chk("par_pop", int'(parity_err), 0);
        step(0, 0, 8'h00, 1);
        q.delete();
        m_hw = 0;
`endif

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                af_thresh = 3'($urandom_range(0, 7));
                ae_thresh = 3'($urandom_range(0, 7));
                #1;
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
